// File: rtl/adc_pkg.sv
// Shared ADC stream constants and offset-binary to signed sample conversion.
// Purely combinational helpers; no latency, no flow control.
package adc_pkg;

    localparam int ADC_DATA_W   = 12;
    localparam int ADC_CH_W     = 5;
    localparam int ADC_MIDSCALE = 2048;
    localparam int SAMPLE_W_MAX = 24;

    typedef logic signed [SAMPLE_W_MAX-1:0] sample_max_t;

    // Result is left-justified into out_w bits; callers keep the low out_w bits.
    function automatic sample_max_t adc_to_signed(input logic [ADC_DATA_W-1:0] code,
                                                  input int out_w);
        logic signed [ADC_DATA_W:0] w_s;
        w_s = $signed({1'b0, code}) - $signed((ADC_DATA_W+1)'(ADC_MIDSCALE));
        return SAMPLE_W_MAX'(w_s) <<< (out_w - ADC_DATA_W);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO; a push appears at the head one cycle later (no bypass).
// Push while full without a same-cycle pop is ignored; pop while empty is ignored.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level    = r_wr_ptr - r_rd_ptr;
    assign w_rd_en    = i_pop & ~o_empty;
    assign w_wr_en    = i_push & (~o_full | w_rd_en);
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/adc_sample_sink.sv
// ADC response sink: channel filter, offset-binary to signed conversion, FWFT sample buffer.
// Hit to sample_valid is 2 cycles when empty; input cannot stall, so a full buffer drops and counts.
module adc_sample_sink
    import adc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic                      adc_response_valid,
    input  logic                      adc_response_startofpacket,
    input  logic                      adc_response_endofpacket,
    input  logic                      adc_response_empty,
    input  logic [ADC_CH_W-1:0]       adc_response_channel,
    input  logic [ADC_DATA_W-1:0]     adc_response_data,
    input  logic [ADC_CH_W-1:0]       cfg_channel,
    input  logic                      enable,
    input  logic                      clear_status,
    output logic                      sample_valid,
    output logic [OUT_W-1:0]          sample_data,
    input  logic                      sample_ready,
    output logic                      overflow,
    output logic                      framing_error,
    output logic [CNT_W-1:0]          drop_count,
    output logic [$clog2(DEPTH):0]    fill_level
);

    typedef logic signed [OUT_W-1:0] sample_t;

    logic        w_hit;
    logic        w_capture;
    logic        w_frame_err;
    sample_max_t w_conv;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_drop;
    logic        w_unused;

    logic        r_s1_vld;
    sample_t     r_s1_dat;
    logic        r_overflow;
    logic        r_framing_error;
    logic [CNT_W-1:0] r_drop_count;

    assign w_hit       = adc_response_valid & enable & (adc_response_channel == cfg_channel);
    assign w_capture   = w_hit & adc_response_startofpacket & adc_response_endofpacket;
    assign w_frame_err = w_hit & ~(adc_response_startofpacket & adc_response_endofpacket);
    assign w_conv      = adc_to_signed(adc_response_data, OUT_W);
    assign w_unused    = ^{adc_response_empty, w_conv};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_s1_vld <= 1'b0;
            r_s1_dat <= '0;
        end else begin
            r_s1_vld <= w_capture;
            if (w_capture) r_s1_dat <= w_conv[OUT_W-1:0];
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .i_clk      (clk_clk),
        .i_rst      (reset_reset),
        .i_push     (r_s1_vld),
        .i_push_dat (r_s1_dat),
        .i_pop      (w_pop),
        .o_head_dat (sample_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (fill_level)
    );

    assign sample_valid = ~w_empty;
    assign w_pop        = sample_valid & sample_ready;
    // A same-cycle pop frees the slot, so only a push against a stalled full buffer is lost.
    assign w_drop       = r_s1_vld & w_full & ~w_pop;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_overflow      <= 1'b0;
            r_framing_error <= 1'b0;
            r_drop_count    <= '0;
        end else begin
            if (w_drop)            r_overflow <= 1'b1;
            else if (clear_status) r_overflow <= 1'b0;

            if (w_frame_err)       r_framing_error <= 1'b1;
            else if (clear_status) r_framing_error <= 1'b0;

            if (clear_status)
                r_drop_count <= w_drop ? CNT_W'(1) : '0;
            else if (w_drop && (r_drop_count != '1))
                r_drop_count <= r_drop_count + CNT_W'(1);
        end
    end

    assign overflow      = r_overflow;
    assign framing_error = r_framing_error;
    assign drop_count    = r_drop_count;

endmodule

// File: doc/adc_sample_sink.md
Name: adc_sample_sink

Overview:
Avalon-ST sink for the modular ADC response stream (valid/sop/eop/empty/channel/12-bit data, no backpressure). It filters beats to one selected channel and converts unsigned offset-binary codes to signed, full-scale audio samples. Samples are buffered in a small FIFO with a valid/ready interface to the effects chain. Overflow, framing-error and drop statistics are exported for the control/status logic.

Parameters:
DEPTH, 16, FIFO depth in samples; power of two, 4..256
OUT_W, 16, output sample width; 12..24
CNT_W, 16, drop-counter width

Ports:
clk_clk  in  1  system clock; same domain as the ADC response stream
reset_reset  in  1  synchronous, active-high reset
adc_response_valid  in  1  response beat valid
adc_response_startofpacket  in  1  SOP
adc_response_endofpacket  in  1  EOP
adc_response_empty  in  1  unused; ignored
adc_response_channel  in  5  channel of beat
adc_response_data  in  12  unsigned ADC code
cfg_channel  in  5  channel to capture
enable  in  1  capture enable
clear_status  in  1  clears overflow, framing_error, drop_count
sample_valid  out  1  FIFO head valid
sample_data  out  OUT_W  signed sample at FIFO head
sample_ready  in  1  downstream accepts head
overflow  out  1  sticky: sample dropped because the FIFO was full
framing_error  out  1  sticky: selected-channel beat without both SOP and EOP
drop_count  out  CNT_W  saturating count of dropped samples
fill_level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock (clk_clk). reset_reset is synchronous and active-high.
- Reset values: sample_valid=0, sample_data=0, overflow=0, framing_error=0, drop_count=0, fill_level=0. The FIFO is flushed and the input register is cleared.
- Reset mid-stream: in-flight and buffered samples are discarded, with no partial output. The first beat accepted after reset deasserts follows normal latency.
- Hit = adc_response_valid & enable & (adc_response_channel==cfg_channel).
- Hit with SOP=1 and EOP=1: the sample is captured. Hit otherwise: the beat is dropped, framing_error is set, and drop_count is not incremented.
- Non-hit beats are ignored silently. While enable=0, no flags or counters change.
- Conversion: s = data - 2048, signed 13-bit, then shifted left by (OUT_W-12). Example values at OUT_W=16:
  - 0 -> 0x8000
  - 2048 -> 0x0000
  - 4095 -> 0x7FF0
  - 2047 -> 0xFFF0
- Stage 1 (input register): captures the converted sample plus a write strobe. There is no stall, because the ADC cannot be backpressured.
- Stage 2 (FIFO write): first-word-fall-through FIFO. Latency from a hit beat to sample_valid is 2 cycles when the FIFO is empty.
- Handshake: a pop occurs when sample_valid & sample_ready. sample_data is stable while sample_valid=1 and sample_ready=0.
- Write when full: the write is accepted if a pop occurs in the same cycle (occupancy unchanged). Otherwise the sample is dropped, overflow is set, and drop_count increments, saturating at 2^CNT_W-1.
- Write and pop on an empty FIFO: the new sample appears the next cycle. There is no bypass.
- fill_level updates on the cycle after a push or pop. Range 0..DEPTH.
- clear_status: zeroes overflow, framing_error and drop_count. If an event occurs in the same cycle, the event wins: flag=1 and count=1.
- FIFO pointers wrap modulo DEPTH. Full/empty detection uses an extra pointer MSB.

Decomposition:
- Package adc_pkg holds:
  - ADC_DATA_W=12, ADC_CH_W=5, ADC_MIDSCALE=2048
  - function adc_to_signed(code, out_w)
  - sample typedef parameterised by OUT_W
- Sub-module sample_fifo (DEPTH, WIDTH): synchronous first-word-fall-through FIFO with push, pop, full, empty and level outputs.

Test Plan:
- cfg_channel=1; codes 0, 2048, 4095 on channel 1 with SOP=EOP=1, sample_ready=1 -> sample_data 0x8000, 0x0000, 0x7FF0, each 2 cycles after its beat, in order.
- Interleaved beats on channels 0/1/2, cfg_channel=2 -> only the channel-2 samples appear. framing_error=0 and drop_count=0.
- sample_ready=0 with DEPTH+3 hits -> fill_level=16, overflow=1, drop_count=3. On draining, the first 16 samples appear in order.
- Full FIFO with a hit and a pop in the same cycle -> fill_level stays 16, no drop, and the new sample is last out.
- Channel-1 hit with EOP=0 -> framing_error=1 and no output. clear_status in the same cycle as an overflow drop -> overflow=1, drop_count=1.
- Reset asserted with 5 samples buffered -> next cycle sample_valid=0, fill_level=0, all flags 0. A post-reset hit is output 2 cycles later.
